mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
- Round-robin arbiter/sequencer sharing one N:1 mux output channel among N_REQ requesters.
- Selects one requester at a time and drives the mux select. Transfers that requester's data beats to a single registered output while downstream ready is high.
- Limits each tenure to MAX_HOLD beats so no requester starves the others.
- Sits between the requester sources and the shared downstream consumer; the mux is the datapath it controls.

Parameters:
- N_REQ, 4, number of requesters (power of two, >=2)
- DW, 8, data width per requester
- MAX_HOLD, 4, max beats per grant tenure (>=1)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- req  input  N_REQ  per-requester request; bit i = requester i has data
- data_in  input  N_REQ*DW  packed requester data; slice i = data_in[i*DW +: DW]
- ready  input  1  downstream accepts a beat this cycle
- grant  output  N_REQ  one-hot current owner; 0 when idle
- sel  output  $clog2(N_REQ)  mux select = index of owner
- data_out  output  DW  registered mux output
- valid_out  output  1  data_out holds a beat transferred in the previous cycle

Behaviour:
- Reset (async, immediate, also mid-tenure): state=IDLE, grant=0, sel=0, rr_ptr=0, hold_cnt=0, data_out=0, valid_out=0.
- State machine has two states: IDLE and OWN.
- IDLE, req==0: stay in IDLE, grant=0.
- IDLE, req!=0: winner = first set req bit searching upward from rr_ptr, wrapping modulo N_REQ. Next cycle: state=OWN, grant=onehot(winner), sel=winner, hold_cnt=0.
- OWN, beat condition: req[sel] && ready.
  - On a beat: data_out<=data_in[sel]; valid_out<=1; hold_cnt<=hold_cnt+1.
  - Otherwise: valid_out<=0 and data_out holds its value.
- OWN, ready low with req[sel] high: ownership kept, no beat, hold_cnt unchanged.
- OWN release, either of:
  - (a) beat occurs with hold_cnt==MAX_HOLD-1;
  - (b) req[sel]==0 (no beat that cycle).
- On release: next state=IDLE, grant=0, rr_ptr<=(sel+1) mod N_REQ. sel holds its last value while idle.
- Arbitration gap: exactly one IDLE cycle between tenures. Beat-to-beat latency across owners is 2 cycles minimum.
- Latency: req asserted in IDLE at cycle t → grant at t+1 → first possible beat at t+1 → valid_out/data_out at t+2.
- Simultaneous release and new requests: handled by the IDLE search from the updated rr_ptr. The just-released requester has lowest priority.
- Single requester held continuously: it regains the grant after each one-cycle gap. Its tenures are MAX_HOLD beats each.
- Requests other than req[sel] are ignored during OWN. Changes to data_in for non-owners have no effect.
- hold_cnt width is $clog2(MAX_HOLD+1); it never wraps because release occurs at MAX_HOLD-1.
- grant is always one-hot or zero. sel always equals the index of the set grant bit while in OWN.

Decomposition:
- Shared package holds:
  - state encoding (ST_IDLE, ST_OWN, 1-bit);
  - localparams SEL_W=$clog2(N_REQ) and CNT_W.
- One natural sub-module: rr_pick.
  - Combinational.
  - Inputs: req and rr_ptr. Outputs: winner index and any_req.
  - Rotate req by rr_ptr, priority-encode, add rr_ptr back mod N_REQ.
- The mux slice select (data_in[sel*DW +: DW]) stays inline in the top.

Test Plan:
- Reset mid-tenure: req=4'b0010, ready=1, assert rst at 3rd beat → grant=0, valid_out=0, data_out=0 immediately; after release, req=4'b0010 re-grants requester 1 (rr_ptr=0 search).
- Round-robin fairness: req=4'b1111 constant, ready=1, MAX_HOLD=4, data_in slices 8'hA0..8'hA3.
  - Grant order is 0,1,2,3,0.
  - Each tenure gives 4 valid_out beats with the owner's value, separated by one idle cycle.
- Backpressure: owner 2, toggle ready 1,0,0,1,1,1.
  - Beats occur only in ready=1 cycles.
  - Exactly 4 beats total, then release, and rr_ptr=3.
- Early release: owner 1, req[1] drops after 2 beats with req=4'b0101 pending.
  - grant→0 for one cycle, then grant=4'b0100 (requester 2 wins over 0).
- Idle/no request: req=0 for 10 cycles → grant=0, valid_out=0, data_out unchanged.
- Wrap-around: rr_ptr=3 after serving requester 2, req=4'b0001 → requester 0 granted; then req=4'b1001 after its tenure → requester 3 granted.

Source files
------------

// File: rtl/mux_rr_arbiter_pkg.sv
// rtl/mux_rr_arbiter_pkg.sv - shared types, default sizes and width helper for the round-robin mux arbiter
package mux_rr_arbiter_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } state_t;

   localparam int N_REQ_DEF    = 4;
   localparam int DW_DEF       = 8;
   localparam int MAX_HOLD_DEF = 4;

   // Index width that stays at least one bit even for degenerate sizes
   function automatic int idx_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam int SEL_W = idx_width(N_REQ_DEF);
   localparam int CNT_W = $clog2(MAX_HOLD_DEF + 1);

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// rtl/mux_rr_arbiter_if.sv - requester/consumer bundle shared by the arbiter and its environment
interface mux_rr_arbiter_if import mux_rr_arbiter_pkg::*; #(
   parameter int N_REQ = N_REQ_DEF,
   parameter int DW    = DW_DEF
) ();

   localparam int SW = idx_width(N_REQ);

   logic [N_REQ-1:0]    req;
   logic [N_REQ*DW-1:0] data_in;
   logic                ready;
   logic [N_REQ-1:0]    grant;
   logic [SW-1:0]       sel;
   logic [DW-1:0]       data_out;
   logic                valid_out;

   modport master (
      output req, data_in, ready,
      input  grant, sel, data_out, valid_out
   );

   modport slave (
      input  req, data_in, ready,
      output grant, sel, data_out, valid_out
   );

endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rtl/mux_rr_arbiter_rr_pick.sv - combinational round-robin winner search starting at the priority pointer
module mux_rr_arbiter_rr_pick import mux_rr_arbiter_pkg::*; #(
   parameter int N_REQ = N_REQ_DEF
) (
   input  logic [N_REQ-1:0]            req,
   input  logic [idx_width(N_REQ)-1:0] ptr,
   output logic [idx_width(N_REQ)-1:0] winner,
   output logic                        any_req
);

   localparam int SW = idx_width(N_REQ);

   logic [N_REQ-1:0] rot;
   logic [SW-1:0]    offset;

   // Rotate so ptr lands at bit 0, take the lowest set bit, then undo the rotation.
   // N_REQ is a power of two, so SW-bit arithmetic wraps modulo N_REQ for free.
   always_comb begin
      rot    = '0;
      offset = '0;
      for (int i = 0; i < N_REQ; i++) begin
         rot[i] = req[SW'(SW'(i) + ptr)];
      end
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) offset = SW'(i);
      end
      winner  = SW'(offset + ptr);
      any_req = |req;
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin owner FSM driving an N:1 mux into a registered output with bounded tenure
module mux_rr_arbiter import mux_rr_arbiter_pkg::*; #(
   parameter int N_REQ    = N_REQ_DEF,
   parameter int DW       = DW_DEF,
   parameter int MAX_HOLD = MAX_HOLD_DEF
) (
   input  logic             clk,
   input  logic             rst,
   mux_rr_arbiter_if.slave  bus
);

   localparam int SW = idx_width(N_REQ);
   localparam int CW = $clog2(MAX_HOLD + 1);

   state_t           state,     state_nx;
   logic [N_REQ-1:0] grant,     grant_nx;
   logic [SW-1:0]    sel,       sel_nx;
   logic [SW-1:0]    rr_ptr,    rr_ptr_nx;
   logic [CW-1:0]    hold_cnt,  hold_cnt_nx;
   logic [DW-1:0]    data_out,  data_out_nx;
   logic             valid_out, valid_out_nx;

   logic [SW-1:0]    winner;
   logic             any_req;
   logic [DW-1:0]    owner_data;

   mux_rr_arbiter_rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req     (bus.req),
      .ptr     (rr_ptr),
      .winner  (winner),
      .any_req (any_req)
   );

   assign owner_data = bus.data_in[sel*DW +: DW];

   // Next-state and datapath decisions; a release always hands lowest priority to the old owner
   always_comb begin
      state_nx     = state;
      grant_nx     = grant;
      sel_nx       = sel;
      rr_ptr_nx    = rr_ptr;
      hold_cnt_nx  = hold_cnt;
      data_out_nx  = data_out;
      valid_out_nx = 1'b0;
      unique case (state)
         ST_IDLE: begin
            grant_nx = '0;
            if (any_req) begin
               state_nx         = ST_OWN;
               grant_nx[winner] = 1'b1;
               sel_nx           = winner;
               hold_cnt_nx      = '0;
            end
         end
         ST_OWN: begin
            if (bus.req[sel]) begin
               if (bus.ready) begin
                  data_out_nx  = owner_data;
                  valid_out_nx = 1'b1;
                  hold_cnt_nx  = hold_cnt + 1'b1;
                  if (hold_cnt == CW'(MAX_HOLD - 1)) begin
                     state_nx  = ST_IDLE;
                     grant_nx  = '0;
                     rr_ptr_nx = sel + 1'b1;
                  end
               end
            end else begin
               state_nx  = ST_IDLE;
               grant_nx  = '0;
               rr_ptr_nx = sel + 1'b1;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // State and output registers; reset clears ownership immediately, even mid-tenure
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         grant     <= '0;
         sel       <= '0;
         rr_ptr    <= '0;
         hold_cnt  <= '0;
         data_out  <= '0;
         valid_out <= 1'b0;
      end else begin
         state     <= state_nx;
         grant     <= grant_nx;
         sel       <= sel_nx;
         rr_ptr    <= rr_ptr_nx;
         hold_cnt  <= hold_cnt_nx;
         data_out  <= data_out_nx;
         valid_out <= valid_out_nx;
      end
   end

   assign bus.grant     = grant;
   assign bus.sel       = sel;
   assign bus.data_out  = data_out;
   assign bus.valid_out = valid_out;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - directed and randomized self-checking bench for mux_rr_arbiter
module tb_mux_rr_arbiter;
   import mux_rr_arbiter_pkg::*;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int MH = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mux_rr_arbiter_if #(.N_REQ(N), .DW(W)) bus ();

   mux_rr_arbiter #(.N_REQ(N), .DW(W), .MAX_HOLD(MH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: owner index (-1 when idle), beats served this tenure, next priority index
   int         m_owner;
   int         m_beats;
   int         m_prio;
   int         m_last;
   logic [W-1:0] m_dout;
   logic       m_vout;

   function automatic int pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_beats = 0;
      m_prio  = 0;
      m_last  = 0;
      m_dout  = '0;
      m_vout  = 1'b0;
   endtask

   task automatic model_edge();
      int w;
      m_vout = 1'b0;
      if (m_owner < 0) begin
         w = pick(bus.req, m_prio);
         if (w >= 0) begin
            m_owner = w;
            m_last  = w;
            m_beats = 0;
         end
      end else if (!bus.req[m_owner]) begin
         m_prio  = (m_owner + 1) % N;
         m_owner = -1;
      end else if (bus.ready) begin
         m_dout  = bus.data_in[m_owner*W +: W];
         m_vout  = 1'b1;
         m_beats = m_beats + 1;
         if (m_beats == MH) begin
            m_prio  = (m_owner + 1) % N;
            m_owner = -1;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic [N-1:0] g;
      g = '0;
      if (m_owner >= 0) g[m_owner] = 1'b1;
      chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
      chk({tag, ".sel"}, 32'(bus.sel), 32'(m_last));
      chk({tag, ".valid_out"}, 32'(bus.valid_out), 32'(m_vout));
      chk({tag, ".data_out"}, 32'(bus.data_out), 32'(m_dout));
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_model(tag);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      check_model("reset");
   endtask

   initial begin
      logic [N-1:0] fg;
      logic         fv;
      logic [W-1:0] fd;
      int           nbeats;
      int           rdy_pat [6] = '{1, 0, 0, 1, 1, 1};

      rst         = 1'b1;
      bus.req     = '0;
      bus.ready   = 1'b0;
      bus.data_in = '0;
      @(negedge clk);
      do_reset();
      chk("reset.grant_zero", 32'(bus.grant), 32'h0);
      chk("reset.valid_zero", 32'(bus.valid_out), 32'h0);

      // Reset mid-tenure: owner 1, reset lands during the third beat
      bus.req     = 4'b0010;
      bus.ready   = 1'b1;
      bus.data_in = 32'h44_33_22_11;
      cycle("mid.grant");
      cycle("mid.beat1");
      cycle("mid.beat2");
      #2 rst = 1'b1;
      #1;
      chk("mid.rst_grant", 32'(bus.grant), 32'h0);
      chk("mid.rst_valid", 32'(bus.valid_out), 32'h0);
      chk("mid.rst_data", 32'(bus.data_out), 32'h0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      check_model("mid.held");
      cycle("mid.regrant");
      chk("mid.regrant_1", 32'(bus.grant), 32'h2);

      // Fairness: everyone requests; expected pattern derived from tenure period MH+1
      do_reset();
      bus.req     = 4'b1111;
      bus.ready   = 1'b1;
      bus.data_in = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      for (int k = 1; k <= 25; k++) begin
         cycle("fair");
         fg = '0;
         if ((k - 1) % (MH + 1) < MH) fg[((k - 1) / (MH + 1)) % N] = 1'b1;
         fv = (k >= 2) && ((k - 2) % (MH + 1) < MH);
         chk("fair.grant", 32'(bus.grant), 32'(fg));
         chk("fair.valid", 32'(bus.valid_out), 32'(fv));
         if (fv) begin
            fd = 8'(8'hA0 + ((k - 2) / (MH + 1)) % N);
            chk("fair.data", 32'(bus.data_out), 32'(fd));
         end
      end

      // Backpressure on owner 2, then wrap-around from priority 3
      do_reset();
      bus.req     = 4'b0100;
      bus.ready   = 1'b0;
      bus.data_in = {8'h3C, 8'h2C, 8'h1C, 8'h0C};
      cycle("bp.grant");
      chk("bp.grant_2", 32'(bus.grant), 32'h4);
      nbeats = 0;
      for (int i = 0; i < 6; i++) begin
         bus.ready = rdy_pat[i][0];
         cycle("bp.beat");
         if (bus.valid_out === 1'b1) nbeats++;
      end
      chk("bp.nbeats", 32'(nbeats), 32'd4);
      chk("bp.released", 32'(bus.grant), 32'h0);
      bus.req   = 4'b0001;
      bus.ready = 1'b1;
      cycle("wrap.grant0");
      chk("wrap.grant_0", 32'(bus.grant), 32'h1);
      for (int i = 0; i < MH; i++) cycle("wrap.beat");
      bus.req = 4'b1001;
      cycle("wrap.grant3");
      chk("wrap.grant_3", 32'(bus.grant), 32'h8);

      // Early release: owner 1 drops after two beats with 0 and 2 pending
      do_reset();
      bus.req   = 4'b0010;
      bus.ready = 1'b1;
      cycle("early.grant");
      cycle("early.beat1");
      cycle("early.beat2");
      bus.req = 4'b0101;
      cycle("early.release");
      chk("early.gap", 32'(bus.grant), 32'h0);
      cycle("early.next");
      chk("early.grant_2", 32'(bus.grant), 32'h4);

      // Idle: no requests for ten cycles once the current tenure drains
      bus.req = '0;
      for (int i = 0; i < 12; i++) cycle("idle");
      chk("idle.grant", 32'(bus.grant), 32'h0);
      chk("idle.valid", 32'(bus.valid_out), 32'h0);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) != 0) bus.req = N'($urandom_range(0, (1 << N) - 1));
         bus.ready   = ($urandom_range(0, 3) != 0);
         bus.data_in = $urandom;
         cycle("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
